// File: rtl/regfile_pkg.sv
// Shared constants and reset-value helper for the multi-port integer register file.
// The optional pending-destination scoreboard is enabled with REGFILE_SCOREBOARD_EN.
package regfile_pkg;

    localparam int XLEN    = 32;
    localparam int NREG_RV = 32;
    localparam int REG_AW  = 5;
    localparam int INIT_W  = 64;

    // Bring-up pattern: register i resets to i+1 so every read is distinguishable.
    function automatic logic [INIT_W-1:0] init_val(input int unsigned idx,
                                                   input int unsigned init_idx);
        if (init_idx != 0) begin
            return 64'(idx) + 64'd1;
        end
        return '0;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: zero/bypass priority mux feeding an rd_en-gated output register.
// With REGFILE_SCOREBOARD_EN the port also registers the pending flag of its address.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DW      = XLEN,
    parameter int AW      = REG_AW,
    parameter int ZERO_R0 = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] reg_val,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
`ifdef REGFILE_SCOREBOARD_EN
    input  logic          pend_bit,
    output logic          rd_busy,
`endif
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] rd_val;

    // Later assignments win: the hardwired zero overrides the write-first bypass.
    always_comb begin
        rd_val = reg_val;
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_val = wr_data;
        end
        if ((ZERO_R0 != 0) && (rd_addr == '0)) begin
            rd_val = '0;
        end
    end

    // rd_en is a plain per-cycle enable: the output captures when it is 1 and holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_val;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_busy <= pend_bit;
        end
    end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised integer register file: one write port, NUM_RD registered read ports.
// Define REGFILE_SCOREBOARD_EN to add claim_* inputs, pend tracking and per-port rd_busy.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW       = XLEN,
    parameter int NREG     = NREG_RV,
    parameter int NUM_RD   = 2,
    parameter int ZERO_R0  = 1,
    parameter int INIT_IDX = 0,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic [NUM_RD-1:0]    rd_en,
    input  logic [NUM_RD*AW-1:0] rd_addr,
`ifdef REGFILE_SCOREBOARD_EN
    input  logic                 claim_en,
    input  logic [AW-1:0]        claim_addr,
    output logic [NUM_RD-1:0]    rd_busy,
`endif
    output logic [NUM_RD*DW-1:0] rd_data
);

    logic [DW-1:0] regs [NREG];
    logic          wr_ok;

    assign wr_ok = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                if ((i == 0) && (ZERO_R0 != 0)) begin
                    regs[i] <= '0;
                end else begin
                    regs[i] <= DW'(init_val(i, INIT_IDX));
                end
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;

    // The claim is applied after the write-back clear so a same-cycle claim keeps the bit set.
    always_comb begin
        pend_next = pend;
        if (wr_en) begin
            pend_next[wr_addr] = 1'b0;
        end
        if (claim_en) begin
            pend_next[claim_addr] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            pend_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] addr_p;
        logic [DW-1:0] reg_val_p;

        assign addr_p    = rd_addr[p*AW +: AW];
        assign reg_val_p = regs[addr_p];

        regfile_read_port #(
            .DW      (DW),
            .AW      (AW),
            .ZERO_R0 (ZERO_R0)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en[p]),
            .rd_addr  (addr_p),
            .reg_val  (reg_val_p),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
`ifdef REGFILE_SCOREBOARD_EN
            .pend_bit (pend_next[addr_p]),
            .rd_busy  (rd_busy[p]),
`endif
            .rd_data  (rd_data[p*DW +: DW])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with INIT_IDX=1, one with INIT_IDX=0, shared stimulus.
// Scoreboard checks are compiled in when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_i1;
    logic [63:0] rd_data_i0;
`ifdef REGFILE_SCOREBOARD_EN
    logic        claim_en;
    logic [4:0]  claim_addr;
    logic [1:0]  rd_busy_i1;
    logic [1:0]  rd_busy_i0;
`endif

    int checks;
    int errors;

    regfile_mp #(.INIT_IDX(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
`ifdef REGFILE_SCOREBOARD_EN
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_busy    (rd_busy_i1),
`endif
        .rd_data    (rd_data_i1)
    );

    regfile_mp #(.INIT_IDX(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
`ifdef REGFILE_SCOREBOARD_EN
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_busy    (rd_busy_i0),
`endif
        .rd_data    (rd_data_i0)
    );

    // Clock: posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] re, input logic [4:0] a1, input logic [4:0] a0);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = {a1, a0};
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
`ifdef REGFILE_SCOREBOARD_EN
        claim_en   = 1'b0;
        claim_addr = 5'd0;
`endif
        #12;
        check("reset_rd_i1", rd_data_i1, 64'd0);
        check("reset_rd_i0", rd_data_i0, 64'd0);
`ifdef REGFILE_SCOREBOARD_EN
        check("reset_busy", {62'd0, rd_busy_i1}, 64'd0);
`endif
        rst = 1'b1;

        // Init pattern: reg5 = 6, reg31 = 32 with INIT_IDX=1
        drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd31, 5'd5);
        cyc();
        check("init_i1", rd_data_i1, {32'd32, 32'd6});
        check("init_i0", rd_data_i0, 64'd0);

        // Write-first bypass on port0; port1 disabled holds 32
        drive(1'b1, 5'd3, 32'hDEADBEEF, 2'b01, 5'd31, 5'd3);
        cyc();
        check("bypass_p0", rd_data_i1, {32'd32, 32'hDEADBEEF});
        drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd3, 5'd3);
        cyc();
        check("after_wr_i1", rd_data_i1, {32'hDEADBEEF, 32'hDEADBEEF});
        check("after_wr_i0", rd_data_i0, {32'hDEADBEEF, 32'hDEADBEEF});

        // Writes to x0 are dropped, including through the bypass
        drive(1'b1, 5'd0, 32'h1234, 2'b11, 5'd0, 5'd0);
        cyc();
        check("x0_bypass", rd_data_i1, 64'd0);
        drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd0, 5'd0);
        cyc();
        check("x0_later", rd_data_i1, 64'd0);

        // Port1 hold while reg7 is rewritten
        drive(1'b0, 5'd0, 32'd0, 2'b10, 5'd7, 5'd9);
        cyc();
        check("p1_reg7_i1", rd_data_i1, {32'd8, 32'd0});
        check("p1_reg7_i0", rd_data_i0, 64'd0);
        drive(1'b1, 5'd7, 32'h55, 2'b00, 5'd7, 5'd7);
        cyc();
        check("hold_1", rd_data_i1, {32'd8, 32'd0});
        drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd7, 5'd7);
        cyc();
        check("hold_2", rd_data_i1, {32'd8, 32'd0});
        cyc();
        check("hold_3", rd_data_i1, {32'd8, 32'd0});
        drive(1'b0, 5'd0, 32'd0, 2'b10, 5'd7, 5'd7);
        cyc();
        check("reenable", rd_data_i1, {32'h55, 32'd0});

        // Asynchronous reset between edges after more writes
        drive(1'b1, 5'd10, 32'hA5A5A5A5, 2'b11, 5'd10, 5'd10);
        cyc();
        check("pre_rst", rd_data_i1, {32'hA5A5A5A5, 32'hA5A5A5A5});
        drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_i1", rd_data_i1, 64'd0);
        check("async_rst_i0", rd_data_i0, 64'd0);
        #1;
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 2'b11, 5'd10, 5'd3);
        cyc();
        check("post_rst_i1", rd_data_i1, {32'd11, 32'd4});
        check("post_rst_i0", rd_data_i0, 64'd0);
        drive(1'b0, 5'd0, 32'd0, 2'b10, 5'd7, 5'd3);
        cyc();
        check("post_rst_r7", rd_data_i1, {32'd8, 32'd4});

`ifdef REGFILE_SCOREBOARD_EN
        // Claim 9, then read it: pending
        drive(1'b0, 5'd0, 32'd0, 2'b00, 5'd0, 5'd0);
        claim_en   = 1'b1;
        claim_addr = 5'd9;
        cyc();
        claim_en = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd0, 5'd9);
        cyc();
        check("claim_busy", {62'd0, rd_busy_i1}, 64'd1);
        check("claim_data", rd_data_i1[31:0], 64'd10);

        // Write and claim 9 together: claim wins, data bypassed
        drive(1'b1, 5'd9, 32'h99, 2'b01, 5'd0, 5'd9);
        claim_en   = 1'b1;
        claim_addr = 5'd9;
        cyc();
        claim_en = 1'b0;
        check("wr_claim_busy", {62'd0, rd_busy_i1}, 64'd1);
        check("wr_claim_data", rd_data_i1[31:0], 64'h99);

        // Write alone clears pending for a same-cycle read
        drive(1'b1, 5'd9, 32'h77, 2'b11, 5'd9, 5'd9);
        cyc();
        check("wr_clear_busy", {62'd0, rd_busy_i1}, 64'd0);
        check("wr_clear_data", rd_data_i1, {32'h77, 32'h77});

        // x0 can never be pending
        drive(1'b0, 5'd0, 32'd0, 2'b01, 5'd0, 5'd0);
        claim_en   = 1'b1;
        claim_addr = 5'd0;
        cyc();
        claim_en = 1'b0;
        check("x0_claim_now", {62'd0, rd_busy_i1}, 64'd0);
        cyc();
        check("x0_claim_later", {62'd0, rd_busy_i1}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the RISC-V core; successor to the fixed 32x32, 2-read-port file.
- One write port from writeback, NUM_RD registered read ports for decode/operand fetch.
- Adds a hardwired-zero x0, write-to-read bypass, per-port read enable/hold, and a reset-time init pattern.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of registers (power of 2, >=2); AW = $clog2(NREG).
- NUM_RD, 2, number of read ports (1..4).
- ZERO_R0, 1, 1 = register 0 reads as 0 and ignores writes.
- INIT_IDX, 0, reset value of reg i: 0 -> all zero; 1 -> i+1, used for bring-up tests.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write register index.
- wr_data  in  DW  write data.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*AW  packed read addresses; port p uses bits [p*AW +: AW].
- rd_data  out  NUM_RD*DW  packed registered read data.
- claim_en  in  1  (feature only) mark the destination pending at issue.
- claim_addr  in  AW  (feature only) destination being claimed.
- rd_busy  out  NUM_RD  (feature only) registered pending flag per port.

Behaviour:
- Reset (rst=0, async): reg i <= (INIT_IDX ? i+1 : 0), except reg 0 <= 0 when ZERO_R0=1. rd_data <= 0, rd_busy <= 0.
- Write: on posedge with wr_en=1, reg[wr_addr] <= wr_data.
  - Dropped when ZERO_R0=1 and wr_addr=0.
- Read latency is 1 cycle. On posedge with rd_en[p]=1, rd_data[p] <= value(rd_addr[p]). With rd_en[p]=0, rd_data[p] holds.
- value(a), in priority order:
  - 0 if ZERO_R0 and a=0;
  - else wr_data if wr_en and wr_addr=a (write-first bypass);
  - else reg[a].
- All ports are independent. Several ports may read the same address in one cycle and each gets the same value.
- Out-of-range addresses cannot occur because NREG is a power of 2.
- Reset mid-operation: all state returns to reset values immediately. The first posedge after rst rises behaves normally.

Optional Feature:
- Macro REGFILE_SCOREBOARD_EN.
- With the macro:
  - Keep a pend[NREG] bit vector, reset to 0.
  - Each posedge: pend[wr_addr] clears on wr_en; pend[claim_addr] sets on claim_en.
  - Same address, same cycle: claim wins and pend stays 1.
  - pend[0] is always 0 when ZERO_R0=1.
  - On posedge with rd_en[p]: rd_busy[p] <= pend_next(rd_addr[p]). Same cycle, same timing as rd_data, with the bypass already applied.
  - rd_en[p]=0 holds rd_busy[p].
- Without the macro: the claim_* ports and rd_busy do not exist, and no pend storage is built.

Decomposition:
- Package regfile_pkg holds:
  - constants XLEN=32, NREG_RV=32, REG_AW=5;
  - the function init_val(idx, INIT_IDX).
- Sub-module regfile_read_port (one per port, generate loop) holds:
  - the bypass/zero priority mux;
  - the rd_en-gated output register;
  - rd_busy when the feature is on.
- The top level holds the storage array, the write logic and pend.

Test Plan:
- Reset with INIT_IDX=1, then read addresses 5 and 31 with rd_en=2'b11 -> next cycle rd_data = {32, 6}. With INIT_IDX=0 -> both 0.
- Write reg 3 = 0xDEADBEEF while port0 reads 3 in the same cycle -> next cycle port0 = 0xDEADBEEF (bypass). The following read of 3 returns the same value.
- Write reg 0 = 0x1234 (ZERO_R0=1) while both ports read 0 -> both 0, now and on every later read.
- Port1 reads 7 (value 8), then rd_en[1]=0 for 3 cycles while reg 7 is written 0x55 -> rd_data[1] stays 8. Re-enabling gives 0x55.
- Assert rst low asynchronously between edges after writes -> rd_data = 0 and regs return to init values without a clock edge.
- REGFILE_SCOREBOARD_EN:
  - claim 9, next cycle read 9 -> rd_busy=1;
  - write 9 and claim 9 in the same cycle -> still busy;
  - write 9 alone -> a same-cycle read gives busy=0 and the new data;
  - claim 0 -> never busy.
